ram64_block_mover: RTL

- Initiator-side engine that drives a single-port RAM64 memory as the master, generating address, in and load and consuming out.
- Executes one block command at a time: FILL a range, COPY a range, or SUM a range.
- Uses a start/busy/done handshake toward the controlling logic.
- Sits between CPU-side control logic and the RAM64 instance, sharing the RAM port via an external mux selected by busy.

---
 rtl/ram_mover_pkg.sv | 24 ++
 rtl/ram_mover_addr_gen.sv | 48 ++++
 rtl/ram64_block_mover.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ram_mover_pkg.sv
// Shared encodings for the RAM64 block mover: opcodes, FSM states and sizes.
package ram_mover_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 16;
  localparam int MAX_COUNT  = 2**RAM_ADDR_W;

  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // ST_COPY_VR is only reachable when read-back verification is built in
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_COPY_RD,
    ST_COPY_WR,
    ST_COPY_VR,
    ST_SUM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_mover_addr_gen.sv
// Source/destination pointers and remaining-word counter for the block mover.
// Pointers wrap modulo 2**ADDR_W; the count is clamped to 2**ADDR_W on load.
module ram_mover_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_start,
  input  logic [ADDR_W-1:0] dst_start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              src_advance,
  input  logic              dst_advance,
  input  logic              word_done,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] remaining;
  logic [ADDR_W:0] clamped_count;

  // Any count with the top bit set is 64 or more, so it saturates to a full sweep
  assign clamped_count = word_count[ADDR_W] ? MAX_WORDS : word_count;

  assign last = (remaining == ONE_WORD);

  // Pointer and counter registers: load on command accept, step as words complete
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= src_start;
      dst_ptr   <= dst_start;
      remaining <= clamped_count;
    end else begin
      if (src_advance) src_ptr <= src_ptr + ADDR_W'(1);
      if (dst_advance) dst_ptr <= dst_ptr + ADDR_W'(1);
      if (word_done)   remaining <= remaining - ONE_WORD;
    end
  end

endmodule

// File: rtl/ram64_block_mover.sv
// RAM64 block mover: master-side engine running one FILL, COPY or SUM command
// at a time over a wrapping address range, with a start/busy/done handshake.
// Optional macro RAM_MOVER_VERIFY_EN adds a read-back compare after each COPY
// write; mismatches set err and are counted (saturating) in result.
module ram64_block_mover
  import ram_mover_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] fill_value,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result
);

  state_t state, next_state;

  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic              last;
  logic              accept;
  logic              src_advance;
  logic              dst_advance;
  logic              word_done;
  logic              capture;
  logic              accumulate;
`ifdef RAM_MOVER_VERIFY_EN
  logic              verify;
`endif

  ram_mover_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .CLK         (CLK),
    .reset       (reset),
    .load        (accept),
    .src_start   (src_addr),
    .dst_start   (dst_addr),
    .word_count  (count),
    .src_advance (src_advance),
    .dst_advance (dst_advance),
    .word_done   (word_done),
    .src_ptr     (src_ptr),
    .dst_ptr     (dst_ptr),
    .last        (last)
  );

  // State register; reset drops straight back to IDLE so no further writes occur
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic and RAM port drive; every output idles at zero
  always_comb begin
    next_state  = state;
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    src_advance = 1'b0;
    dst_advance = 1'b0;
    word_done   = 1'b0;
    capture     = 1'b0;
    accumulate  = 1'b0;
`ifdef RAM_MOVER_VERIFY_EN
    verify      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (count == '0 || op == OP_RSVD) begin
            next_state = ST_DONE;
          end else begin
            case (op)
              OP_FILL: next_state = ST_FILL;
              OP_COPY: next_state = ST_COPY_RD;
              default: next_state = ST_SUM;
            endcase
          end
        end
      end
      ST_FILL: begin
        busy        = 1'b1;
        mem_address = dst_ptr;
        mem_in      = fill_q;
        mem_load    = 1'b1;
        dst_advance = 1'b1;
        word_done   = 1'b1;
        if (last) next_state = ST_DONE;
      end
      ST_COPY_RD: begin
        busy        = 1'b1;
        mem_address = src_ptr;
        capture     = 1'b1;
        src_advance = 1'b1;
        next_state  = ST_COPY_WR;
      end
      ST_COPY_WR: begin
        busy        = 1'b1;
        mem_address = dst_ptr;
        mem_in      = hold;
        mem_load    = 1'b1;
`ifdef RAM_MOVER_VERIFY_EN
        next_state  = ST_COPY_VR;
`else
        dst_advance = 1'b1;
        word_done   = 1'b1;
        next_state  = last ? ST_DONE : ST_COPY_RD;
`endif
      end
`ifdef RAM_MOVER_VERIFY_EN
      ST_COPY_VR: begin
        busy        = 1'b1;
        mem_address = dst_ptr;
        verify      = 1'b1;
        dst_advance = 1'b1;
        word_done   = 1'b1;
        next_state  = last ? ST_DONE : ST_COPY_RD;
      end
`endif
      ST_SUM: begin
        busy        = 1'b1;
        mem_address = src_ptr;
        accumulate  = 1'b1;
        src_advance = 1'b1;
        word_done   = 1'b1;
        if (last) next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath registers: command latch, copy holding word, result and sticky error
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hold   <= '0;
      fill_q <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) begin
        fill_q <= fill_value;
        result <= '0;
        err    <= (op == OP_RSVD);
      end
      if (capture)    hold   <= mem_out;
      if (accumulate) result <= result + mem_out;
`ifdef RAM_MOVER_VERIFY_EN
      if (verify && (mem_out != hold)) begin
        err <= 1'b1;
        if (result != '1) result <= result + DATA_W'(1);
      end
`endif
    end
  end

endmodule
